chk_report_sched: RTL and testbench
===================================

# chk_report_sched

Scheduler that serialises result reports from N checker instances bound into target modules into one ordered report channel. Checkers raise a request with a got/expected payload. The block grants them round-robin, accepts each checker's report once, tallies passes and failures, and flags completion once every checker has reported. It sits in the test top, between the bound checkers and the single `$write`/`$finish` reporting logic.

## Interface
- `N_CHK`, default 4 — number of checker requesters (2..16).
- `DW`, default 8 — width of got/exp payload.
- `CW`, default `$clog2(N_CHK+1)` — counter width (derived; do not override).

Ports:
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req` in N_CHK — per-checker report request; held until matching `ack`.
- `got` in N_CHK*DW — per-checker observed value, slice i = `[i*DW +: DW]`.
- `exp` in N_CHK*DW — per-checker expected value, same slicing.
- `ack` out N_CHK — one-hot, one-cycle pulse accepting a checker's report.
- `out_valid` out 1 — report available on output channel.
- `out_ready` in 1 — consumer accepts report.
- `out_id` out `$clog2(N_CHK)` — index of reporting checker.
- `out_got`, `out_exp` out DW each — latched payload.
- `out_mismatch` out 1 — `out_got != out_exp`.
- `pass_cnt`, `fail_cnt` out CW — accepted-report tallies.
- `all_done` out 1 — every checker has reported; sticky.

## Operation
- State machine:
  - IDLE — look for an eligible requester.
  - HOLD — report on the output channel, waiting for the consumer.
  - DONE — all checkers reported.
- Eligible requester: `req[i]=1` and `seen[i]=0`.
- Requests from already-seen checkers are ignored, never acked, and not counted.
- IDLE, with any eligible requester:
  - Grant the first eligible index at or after `ptr`, wrapping modulo N_CHK.
  - Latch `id`, `got` and `exp`.
  - Register `ack[id]=1` and `out_valid=1`; go to HOLD.
- HOLD:
  - `ack` returns to 0 after one cycle.
  - `out_*` stay stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`:
    - `seen[id]<=1`.
    - `ptr<=(id+1) mod N_CHK`.
    - Increment `fail_cnt` if mismatch, else `pass_cnt`.
    - Drop `out_valid`.
    - Next state is DONE if `seen` becomes all-ones, else IDLE.
- DONE: `all_done=1`, no grants, all requests ignored; left only by `rst`.
- Mismatch is a 2-state compare of the latched values.
- Counters cannot overflow: CW covers N_CHK.
- Requester contract: payload stable while `req` is high; `req` deasserts the cycle after `ack`. A `req` that drops before grant is simply not served.

## Timing
- Reset values:
  - `ack=0`, `out_valid=0`, `out_id=0`, `out_got=0`, `out_exp=0`, `out_mismatch=0`.
  - `pass_cnt=0`, `fail_cnt=0`, `all_done=0`.
  - Internal: `seen=0`, `ptr=0`, state IDLE.
- Latency: eligible `req` sampled at edge k → `ack` and `out_valid` high after edge k.
- Throughput: with `out_ready` tied high, `out_valid` is high for one cycle, followed by one IDLE cycle. Peak rate is one report per 2 cycles.
- Counters and `seen` update on the handshake edge. `all_done` rises on the edge after the final handshake.
- New request arriving while in HOLD: waits and is arbitrated on the next IDLE cycle.
- `rst` mid-HOLD: pending report dropped with no count, `out_valid` low next cycle, and `seen` cleared, so every checker may report again.
- `rst` has priority over a simultaneous handshake.

## Structure
- Package `chk_report_pkg`:
  - `typedef enum logic [1:0] {IDLE, HOLD, DONE} chk_state_e`.
  - Default `N_CHK` and `DW` constants.
- Sub-module `chk_rr_arbiter`:
  - Combinational first-eligible search from `ptr` over the `req & ~seen` mask.
  - Outputs `gnt_valid` and `gnt_id`.
- Top-level `chk_report_sched` holds the FSM, payload latch, counters and `seen`/`ptr` registers.

## Test plan
- Single checker: `req[2]`, got=8'h05, exp=8'h05, `out_ready=1` → `ack[2]` next cycle, `out_id=2`, `out_mismatch=0`, `pass_cnt=1`.
- Round-robin: `req=4'b1111` held (each bit drops after its own ack), `ptr=0` → grant order 0,1,2,3. `all_done=1` the cycle after the 4th handshake, `pass_cnt+fail_cnt=4`.
- Backpressure: `out_ready=0` for 5 cycles with report got=8'h22, exp=8'h32 → `out_*` stable for 5 cycles, `fail_cnt` increments only on the handshake edge, `out_mismatch=1`.
- Repeat request: checker 1 reports, then raises `req[1]` again → no second `ack[1]`, counts unchanged.
- Reset mid-HOLD: `rst` on the cycle `out_ready` rises → no count, `out_valid=0`, `seen` cleared, checker may be re-served.
- DONE lock: after `all_done`, `req=4'b1111` → `ack` stays 0 and `out_valid` stays 0 for 10 cycles.

Source files
------------

// File: rtl/chk_report_pkg.sv
// chk_report_pkg: shared FSM encoding and default sizing for the checker report scheduler
package chk_report_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} chk_state_e;
  localparam int N_CHK_DEF = 4;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/chk_rr_arbiter.sv
// chk_rr_arbiter: combinational first-eligible search starting at ptr, wrapping modulo N_CHK
module chk_rr_arbiter #(
  parameter int N_CHK = 4
) (
  input  logic [N_CHK-1:0]         req,
  input  logic [N_CHK-1:0]         seen,
  input  logic [$clog2(N_CHK)-1:0] ptr,
  output logic                     gnt_valid,
  output logic [$clog2(N_CHK)-1:0] gnt_id
);
  localparam int IW = $clog2(N_CHK);
  // Scan from the farthest offset down so the nearest eligible index wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id = '0;
    for (int j = N_CHK - 1; j >= 0; j--) begin
      if (req[IW'((int'(ptr) + j) % N_CHK)] && !seen[IW'((int'(ptr) + j) % N_CHK)]) begin
        gnt_valid = 1'b1;
        gnt_id = IW'((int'(ptr) + j) % N_CHK);
      end
    end
  end
endmodule

// File: rtl/chk_report_sched.sv
// chk_report_sched: serialises one report per checker onto a single ready/valid channel and tallies results
module chk_report_sched
  import chk_report_pkg::*;
#(
  parameter int N_CHK = N_CHK_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = $clog2(N_CHK + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CHK-1:0]         req,
  input  logic [N_CHK*DW-1:0]      got,
  input  logic [N_CHK*DW-1:0]      exp,
  output logic [N_CHK-1:0]         ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_CHK)-1:0] out_id,
  output logic [DW-1:0]            out_got,
  output logic [DW-1:0]            out_exp,
  output logic                     out_mismatch,
  output logic [CW-1:0]            pass_cnt,
  output logic [CW-1:0]            fail_cnt,
  output logic                     all_done
);
  localparam int IW = $clog2(N_CHK);
  chk_state_e state_q, state_d;
  logic [N_CHK-1:0] seen_q, seen_d, ack_q, ack_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_id;
  logic [DW-1:0] got_q, got_d, exp_q, exp_d;
  logic [CW-1:0] pass_q, pass_d, fail_q, fail_d;
  logic gnt_valid;

  chk_rr_arbiter #(.N_CHK(N_CHK)) u_arb (
    .req(req),
    .seen(seen_q),
    .ptr(ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );

  always_comb begin
    state_d = state_q;
    seen_d = seen_q;
    ptr_d = ptr_q;
    id_d = id_q;
    got_d = got_q;
    exp_d = exp_q;
    pass_d = pass_q;
    fail_d = fail_q;
    ack_d = '0;
    case (state_q)
      IDLE: if (gnt_valid) begin
        state_d = HOLD;
        id_d = gnt_id;
        got_d = got[gnt_id*DW +: DW];
        exp_d = exp[gnt_id*DW +: DW];
        ack_d = N_CHK'(1) << gnt_id;
      end
      HOLD: if (out_ready) begin
        seen_d = seen_q | (N_CHK'(1) << id_q);
        ptr_d = (id_q == IW'(N_CHK - 1)) ? '0 : id_q + 1'b1;
        fail_d = out_mismatch ? fail_q + 1'b1 : fail_q;
        pass_d = out_mismatch ? pass_q : pass_q + 1'b1;
        state_d = &seen_d ? DONE : IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seen_q <= '0;
      ptr_q <= '0;
      id_q <= '0;
      got_q <= '0;
      exp_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q <= seen_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      got_q <= got_d;
      exp_q <= exp_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ack_q <= ack_d;
    end
  end

  assign ack = ack_q;
  assign out_valid = state_q == HOLD;
  assign out_id = id_q;
  assign out_got = got_q;
  assign out_exp = exp_q;
  assign out_mismatch = got_q != exp_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign all_done = state_q == DONE;
endmodule

// File: tb/tb_chk_report_sched.sv
// tb_chk_report_sched: directed and randomized checks of chk_report_sched against a transaction-level reference model
module tb_chk_report_sched;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] got = '0;
  logic [N*DW-1:0] exp = '0;
  logic out_ready = 1'b0;
  logic [N-1:0] ack;
  logic out_valid, out_mismatch, all_done;
  logic [1:0] out_id;
  logic [DW-1:0] out_got, out_exp;
  logic [CW-1:0] pass_cnt, fail_cnt;

  chk_report_sched #(.N_CHK(N), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .got(got),
    .exp(exp),
    .ack(ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id(out_id),
    .out_got(out_got),
    .out_exp(out_exp),
    .out_mismatch(out_mismatch),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Reference: a report is either pending on the channel or not; the run is either finished or not
  bit m_pending, m_finished;
  bit [N-1:0] m_seen;
  logic [N-1:0] m_ack;
  int m_ptr, m_id, m_pass, m_fail;
  logic [DW-1:0] m_got, m_exp;
  logic [N-1:0] prev_ack = '0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pending = 0;
      m_finished = 0;
      m_seen = '0;
      m_ack = '0;
      m_ptr = 0;
      m_id = 0;
      m_got = '0;
      m_exp = '0;
      m_pass = 0;
      m_fail = 0;
    end else begin
      m_ack = '0;
      if (m_finished) begin
      end else if (m_pending) begin
        if (out_ready) begin
          m_seen[m_id] = 1'b1;
          m_ptr = (m_id + 1) % N;
          if (m_got != m_exp) m_fail++;
          else m_pass++;
          m_pending = 0;
          m_finished = (m_seen == '1);
        end
      end else begin
        for (int j = 0; j < N; j++) begin
          int i;
          i = (m_ptr + j) % N;
          if (req[i] && !m_seen[i]) begin
            m_id = i;
            m_got = got[i*DW +: DW];
            m_exp = exp[i*DW +: DW];
            m_ack[i] = 1'b1;
            m_pending = 1;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ack", 32'(ack), 32'(m_ack));
    chk("out_valid", 32'(out_valid), 32'(m_pending));
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("out_got", 32'(out_got), 32'(m_got));
    chk("out_exp", 32'(out_exp), 32'(m_exp));
    chk("out_mismatch", 32'(out_mismatch), 32'(m_got != m_exp));
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    chk("all_done", 32'(all_done), 32'(m_finished));
  endtask

  // One clock: model sees the same sampled inputs as the DUT; requesters drop req the cycle after their ack
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    req = req & ~prev_ack;
    prev_ack = ack;
  endtask

  task automatic load(input int i, input logic [DW-1:0] g, input logic [DW-1:0] e);
    got[i*DW +: DW] = g;
    exp[i*DW +: DW] = e;
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rr_idx;
    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Single checker, matching payload
    out_ready = 1'b1;
    load(2, 8'h05, 8'h05);
    tick();
    chk("single_ack", 32'(ack), 32'h4);
    tick();
    chk("single_pass", 32'(pass_cnt), 32'd1);
    tick();

    // Round-robin from ptr 0 with all four requesting
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 8'(8'h10 + i), 8'(8'h10 + (i & 1)));
    rr_idx = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack != '0) begin
        chk("rr_order", 32'(out_id), 32'(rr_idx));
        rr_idx++;
      end
    end
    chk("rr_grants", 32'(rr_idx), 32'd4);
    chk("rr_total", 32'(pass_cnt) + 32'(fail_cnt), 32'd4);

    // DONE lock: no grants for 10 cycles
    for (int c = 0; c < 10; c++) begin
      req = '1;
      tick();
    end

    // Backpressure with a mismatching report, then repeat request from the same checker
    do_reset();
    out_ready = 1'b0;
    load(1, 8'h22, 8'h32);
    tick();
    for (int c = 0; c < 5; c++) tick();
    chk("bp_fail_hold", 32'(fail_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_fail_hs", 32'(fail_cnt), 32'd1);
    for (int c = 0; c < 5; c++) begin
      req[1] = 1'b1;
      tick();
    end
    req = '0;

    // Reset on the cycle out_ready rises mid-HOLD, then re-serve the same checker
    do_reset();
    load(3, 8'h44, 8'h44);
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    load(3, 8'h44, 8'h44);
    tick();
    tick();
    chk("rst_reserve", 32'(pass_cnt), 32'd1);

    // Randomized episodes with occasional reset
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(3) == 0) begin
            logic [DW-1:0] g;
            g = DW'($urandom);
            load(i, g, $urandom_range(1) == 0 ? g : DW'($urandom));
          end else if (req[i] && $urandom_range(15) == 0) begin
            req[i] = 1'b0;
          end
        end
        out_ready = $urandom_range(2) != 0;
        rst = $urandom_range(49) == 0;
        tick();
      end
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
